// File: rtl/memoria_pkg.sv
// memoria_pkg
// Shared constants and types for operand memory B and its byte-stream loader.
//   ANCHO_DATO    : memory word width
//   PROF_ADDR     : address width (2**PROF_ADDR words)
//   ANCHO_BYTE    : width of one streamed byte
//   ANCHO_CUENTA  : width of the word-count request
//   MAX_PALABRAS  : largest legal word count for one load
//   estado_t      : loader FSM state encoding
package memoria_pkg;

  localparam int ANCHO_DATO   = 32;
  localparam int PROF_ADDR    = 3;
  localparam int ANCHO_BYTE   = 8;
  localparam int ANCHO_CUENTA = 4;
  localparam int MAX_PALABRAS = 8;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CARGA   = 2'd1,
    ESCRIBE = 2'd2,
    FIN     = 2'd3
  } estado_t;

  // A load request must ask for at least one word and no more than the memory holds.
  function automatic logic cuenta_valida(input logic [ANCHO_CUENTA-1:0] cuenta);
    return (cuenta != '0) && (cuenta <= ANCHO_CUENTA'(MAX_PALABRAS));
  endfunction

endpackage

// File: rtl/banco_operandos.sv
// banco_operandos
// 2**PROF_ADDR x ANCHO_DATO register array holding operand B.
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low clear of every word
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   addr_i     : read address (ALU side)
//   operador_o : memory[addr_i], combinational, no write bypass
module banco_operandos
  import memoria_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [PROF_ADDR-1:0]  waddr_i,
  input  logic [ANCHO_DATO-1:0] wdata_i,
  input  logic [PROF_ADDR-1:0]  addr_i,
  output logic [ANCHO_DATO-1:0] operador_o
);

  logic [ANCHO_DATO-1:0] r_mem [2**PROF_ADDR];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2**PROF_ADDR; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // A word being written still reads its old value until the write edge.
  assign operador_o = r_mem[addr_i];

endmodule

// File: rtl/cargador_memoria_b.sv
// cargador_memoria_b
// Operand memory B with a byte-stream loader. A host streams bytes over a
// valid/ready handshake; bytes are packed LSB-first into words and written
// to consecutive addresses (modulo the depth) starting at a captured base.
//   clk_i, rst_n_i : clock (rising edge), async active-low reset
//   inicio_i       : start pulse, only looked at in REPOSO
//   base_addr_i    : first word address, captured with inicio_i
//   cuenta_i       : number of words, legal range 1..MAX_PALABRAS
//   aborta_i       : abandon the current load (partial word dropped)
//   byte_i         : streamed byte
//   byte_valido_i  : byte_i is valid
//   byte_listo_o   : loader can take a byte this cycle
//   ocupado_o      : loader is not in REPOSO
//   hecho_o        : single-cycle pulse when a load completes
//   error_o        : sticky, last inicio_i carried an illegal cuenta_i
//   addr_i         : ALU read address
//   operador_o     : memory[addr_i], combinational
//
// Handshake: a byte transfers on a rising edge where byte_valido_i and
// byte_listo_o are both 1 (and aborta_i is 0); byte_listo_o never depends
// on byte_valido_i, and the host may hold byte_valido_i low indefinitely.
module cargador_memoria_b
  import memoria_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    inicio_i,
  input  logic [PROF_ADDR-1:0]    base_addr_i,
  input  logic [ANCHO_CUENTA-1:0] cuenta_i,
  input  logic                    aborta_i,
  input  logic [ANCHO_BYTE-1:0]   byte_i,
  input  logic                    byte_valido_i,
  output logic                    byte_listo_o,
  output logic                    ocupado_o,
  output logic                    hecho_o,
  output logic                    error_o,
  input  logic [PROF_ADDR-1:0]    addr_i,
  output logic [ANCHO_DATO-1:0]   operador_o
);

  localparam int         BYTES_POR_PALABRA = ANCHO_DATO / ANCHO_BYTE;
  localparam logic [1:0] ULTIMO_BYTE       = 2'(BYTES_POR_PALABRA - 1);

  estado_t                 r_estado;
  estado_t                 w_estado_sig;
  logic [PROF_ADDR-1:0]    r_dir;
  logic [ANCHO_CUENTA-1:0] r_palabras;
  logic [1:0]              r_byte_cnt;
  logic [ANCHO_DATO-1:0]   r_palabra;
  logic                    r_error;
  logic                    w_acepta;
  logic                    w_we;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next state and handshake/strobe decode; abort always wins.
  always_comb begin
    w_estado_sig = r_estado;
    w_acepta     = 1'b0;
    w_we         = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (inicio_i && cuenta_valida(cuenta_i)) begin
          w_estado_sig = CARGA;
        end
      end
      CARGA: begin
        if (aborta_i) begin
          w_estado_sig = REPOSO;
        end else begin
          w_acepta = byte_valido_i;
          if (byte_valido_i && (r_byte_cnt == ULTIMO_BYTE)) begin
            w_estado_sig = ESCRIBE;
          end
        end
      end
      ESCRIBE: begin
        if (aborta_i) begin
          w_estado_sig = REPOSO;
        end else begin
          w_we         = 1'b1;
          w_estado_sig = (r_palabras == ANCHO_CUENTA'(1)) ? FIN : CARGA;
        end
      end
      FIN: begin
        w_estado_sig = REPOSO;
      end
      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  // Datapath: request capture, byte packer and counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dir      <= '0;
      r_palabras <= '0;
      r_byte_cnt <= '0;
      r_palabra  <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (inicio_i) begin
            if (cuenta_valida(cuenta_i)) begin
              r_dir      <= base_addr_i;
              r_palabras <= cuenta_i;
              r_byte_cnt <= '0;
              r_error    <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        CARGA: begin
          if (aborta_i) begin
            r_byte_cnt <= '0;
            r_palabra  <= '0;
          end else if (w_acepta) begin
            // Shift in from the top: after four bytes the first one sits in [7:0].
            r_palabra  <= {byte_i, r_palabra[ANCHO_DATO-1:ANCHO_BYTE]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ESCRIBE: begin
          if (!aborta_i) begin
            r_dir      <= r_dir + PROF_ADDR'(1);
            r_palabras <= r_palabras - ANCHO_CUENTA'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign byte_listo_o = (r_estado == CARGA);
  assign ocupado_o    = (r_estado != REPOSO);
  assign hecho_o      = (r_estado == FIN) && !aborta_i;
  assign error_o      = r_error;

  banco_operandos u_banco (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .we_i       (w_we),
    .waddr_i    (r_dir),
    .wdata_i    (r_palabra),
    .addr_i     (addr_i),
    .operador_o (operador_o)
  );

endmodule

// File: doc/cargador_memoria_b.md
# cargador_memoria_b

Writable operand-B store with a byte-stream loader: a host streams bytes in over a valid/ready handshake, the block packs them into 32-bit words and writes them into an 8-entry operand memory starting at a chosen base address. The ALU reads the same memory through a combinational read port (`addr_i` → `operador_o`). This is the write side of operand memory B, replacing fixed initial contents with runtime loading.

## Interface
- `ANCHO_DATO`, 32, memory word width
- `PROF_ADDR`, 3, address width (2**PROF_ADDR words)
- `ANCHO_BYTE`, 8, width of one streamed byte
- `clk_i` input 1, single clock, rising edge
- `rst_n_i` input 1, reset, asynchronous, active-low
- `inicio_i` input 1, start pulse, sampled only in REPOSO
- `base_addr_i` input 3, first word address, captured with `inicio_i`
- `cuenta_i` input 4, words to load, valid range 1..8, captured with `inicio_i`
- `aborta_i` input 1, abort the current load
- `byte_i` input 8, streamed byte
- `byte_valido_i` input 1, `byte_i` is valid
- `byte_listo_o` output 1, loader accepts a byte this cycle
- `ocupado_o` output 1, loader not in REPOSO
- `hecho_o` output 1, one-cycle pulse, load complete
- `error_o` output 1, sticky, last `inicio_i` had an illegal `cuenta_i`
- `addr_i` input 3, ALU read address
- `operador_o` output 32, `memory[addr_i]`, combinational

## Operation
- FSM states: REPOSO, CARGA, ESCRIBE, FIN.
- REPOSO:
  - `inicio_i` with `cuenta_i` in 1..8 captures base/count, clears `error_o`, and moves to CARGA.
  - `cuenta_i` of 0 or 9..15 sets `error_o` and stays in REPOSO.
- CARGA:
  - `byte_listo_o`=1.
  - A byte is accepted on an edge where `byte_valido_i`&&`byte_listo_o`.
  - Bytes are packed LSB-first: 1st byte → [7:0], 4th → [31:24].
  - A 2-bit byte counter tracks position; the 4th accepted byte moves the FSM to ESCRIBE.
- ESCRIBE:
  - `byte_listo_o`=0.
  - The assembled word is written to `memory[dir]` on the ending edge.
  - `dir` increments modulo 8 and the word counter decrements.
  - Next state is CARGA if words remain, else FIN.
- FIN: `hecho_o`=1 for this cycle only, then REPOSO.
- `inicio_i` outside REPOSO is ignored; `error_o` is unchanged.
- `aborta_i` in CARGA/ESCRIBE/FIN:
  - Next state is REPOSO with no `hecho_o`.
  - The partial word is discarded.
  - Words already written are kept.
  - `aborta_i` has priority over a simultaneous byte accept or write; the ESCRIBE write is suppressed.
- Address wrap: base 6, count 4 writes 6, 7, 0, 1.
- Read port is purely combinational on `addr_i`. A word being written shows old data during ESCRIBE and new data after the edge. There is no bypass.

## Timing
- Reset (async assert, sync-released use) sets:
  - state REPOSO, all counters 0, memory all zeros;
  - `byte_listo_o`=0, `ocupado_o`=0, `hecho_o`=0, `error_o`=0;
  - `operador_o`=0 for every address.
- Reset mid-load returns to REPOSO and clears memory; no `hecho_o`.
- `inicio_i` at edge T puts the FSM in CARGA at T+1, with `byte_listo_o`=1 in that cycle.
- Peak rate is 4 bytes in 4 cycles, then 1 ESCRIBE cycle, i.e. 5 cycles/word.
  - 4th byte accepted at edge N → ESCRIBE during N..N+1 → data visible on `operador_o` after edge N+1.
- Last word's ESCRIBE is followed by FIN (one cycle with `hecho_o`=1), then REPOSO.
- Minimum load of 1 word takes 1 + 4 + 1 + 1 = 7 cycles from `inicio_i` to return to REPOSO.
- `byte_valido_i` may stall arbitrarily; the loader holds state with no timeout.
- `ocupado_o` is 1 in CARGA, ESCRIBE and FIN.

## Structure
- Shared package `memoria_pkg`: ANCHO_DATO, PROF_ADDR, ANCHO_BYTE, MAX_PALABRAS=8, FSM state encoding (REPOSO, CARGA, ESCRIBE, FIN).
- Sub-module `banco_operandos`:
  - 8×32 register array with async active-low clear, single synchronous write port (`we`, `waddr`, `wdata`), combinational read port.
  - Shares its read-side port names with the existing read-only operand-B memory.
- Top holds the FSM, byte packer, and address/word/byte counters.

## Test plan
- Reset, then `inicio_i` base 0 count 2, bytes 00,FF,00,FF,93,69,0F,35 → `memory[0]`=FF00FF00, `memory[1]`=350F6993, one `hecho_o` pulse 11 cycles after `inicio_i`, all other words 0.
- Base 6, count 4, bytes 01..10 → words land at 6,7,0,1 (04030201, 08070605, 0C0B0A09, 100F0E0D); addresses 2..5 unchanged.
- `cuenta_i`=0, then `cuenta_i`=9 → `error_o`=1, FSM stays REPOSO, memory unchanged; a following legal `inicio_i` clears `error_o`.
- `byte_valido_i` toggled randomly; `aborta_i` asserted after the 2nd byte of word 1 on a count-3 load → word 0 written, word 1 not written, no `hecho_o`, `byte_listo_o`=0 next cycle.
- `rst_n_i` pulsed low mid-ESCRIBE → outputs and memory 0 immediately; the write does not occur.
- `inicio_i` held high throughout a load, with `addr_i` reading the target address during ESCRIBE → no restart, old value during ESCRIBE, new value the cycle after.
